// File: rtl/game_pkg.sv
// Shared encodings for the game timer sequencer: game FSM, target FSM and result codes.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } game_state_t;

  typedef enum logic [1:0] {
    T_IDLE,
    T_ARMED,
    T_HIT,
    T_MISS
  } tgt_state_t;

  localparam logic [1:0] RES_NONE = 2'd0;
  localparam logic [1:0] RES_HIT  = 2'd1;
  localparam logic [1:0] RES_MISS = 2'd2;

endpackage

// File: rtl/target_ctrl.sv
// One target's reaction window: arms on software request during a game, then
// resolves to hit (sensor) or miss (window expiry) until software clears it.
module target_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TARGET_MS = 1000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_run,
  input  logic        i_tick,
  input  logic        i_active,
  input  logic        i_sensor,
  input  logic        i_force_idle,
  output logic [15:0] o_timer,
  output logic [1:0]  o_code
);

  localparam logic [15:0] LOAD = 16'(TARGET_MS);

  tgt_state_t  r_state, w_state_nxt;
  logic [15:0] r_timer, w_timer_nxt;
  logic [1:0]  r_code,  w_code_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= T_IDLE;
      r_timer <= '0;
      r_code  <= RES_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_code  <= w_code_nxt;
    end
  end

  // Priority: game end > cancel > sensor > expiry tick.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_code_nxt  = r_code;
    if (i_force_idle) begin
      w_state_nxt = T_IDLE;
      w_timer_nxt = '0;
      w_code_nxt  = RES_NONE;
    end else begin
      unique case (r_state)
        T_IDLE: begin
          if (i_run && i_active) begin
            w_state_nxt = T_ARMED;
            w_timer_nxt = LOAD;
          end
        end
        T_ARMED: begin
          if (!i_active) begin
            w_state_nxt = T_IDLE;
            w_timer_nxt = '0;
            w_code_nxt  = RES_NONE;
          end else if (i_sensor) begin
            w_state_nxt = T_HIT;
            w_code_nxt  = RES_HIT;
          end else if (i_tick) begin
            if (r_timer == 16'd1) begin
              w_state_nxt = T_MISS;
              w_timer_nxt = '0;
              w_code_nxt  = RES_MISS;
            end else begin
              w_timer_nxt = r_timer - 16'd1;
            end
          end
        end
        T_HIT, T_MISS: begin
          if (!i_active) begin
            w_state_nxt = T_IDLE;
            w_timer_nxt = '0;
            w_code_nxt  = RES_NONE;
          end
        end
        default: begin
          w_state_nxt = T_IDLE;
          w_timer_nxt = '0;
          w_code_nxt  = RES_NONE;
        end
      endcase
    end
  end

  assign o_timer = r_timer;
  assign o_code  = r_code;

endmodule

// File: rtl/game_timer_ctrl.sv
// Game sequencer: ms prescaler, game countdown FSM and two target windows,
// driving the register file's hardware-write ports.
module game_timer_ctrl
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned TARGET_MS = 1000,
  parameter int unsigned GAME_MS   = 60000
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        game_start,
  input  logic [31:0] t1active_read,
  input  logic [31:0] t2active_read,
  input  logic        t1_sensor,
  input  logic        t2_sensor,
  output logic [31:0] timer1_write,
  output logic [31:0] timer2_write,
  output logic [31:0] gametimer_write,
  output logic [31:0] t1hit_write,
  output logic [31:0] t2hit_write,
  output logic        game_over
);

  localparam int          PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0] DIV_MAX = PW'(TICK_DIV - 1);
  localparam logic [23:0] GAME_LOAD = 24'(GAME_MS);

  game_state_t   r_state, w_state_nxt;
  logic [23:0]   r_gtimer, w_gtimer_nxt;
  logic [PW-1:0] r_presc;
  logic          w_run, w_tick, w_game_end;
  logic [15:0]   w_t1_timer, w_t2_timer;
  logic [1:0]    w_t1_code, w_t2_code;
  logic          w_unused;

  assign w_unused   = ^{t1active_read[31:1], t2active_read[31:1]};
  assign w_run      = (r_state == RUN);
  assign w_tick     = w_run && (r_presc == DIV_MAX);
  assign w_game_end = w_tick && (r_gtimer == 24'd1);

  // Held at zero outside RUN, so every RUN entry starts a full tick period.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_presc <= '0;
    end else if (!w_run || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state  <= IDLE;
      r_gtimer <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gtimer <= w_gtimer_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_gtimer_nxt = r_gtimer;
    unique case (r_state)
      IDLE, OVER: begin
        if (game_start) begin
          w_state_nxt  = RUN;
          w_gtimer_nxt = GAME_LOAD;
        end
      end
      RUN: begin
        if (w_game_end) begin
          w_state_nxt  = OVER;
          w_gtimer_nxt = '0;
        end else if (w_tick) begin
          w_gtimer_nxt = r_gtimer - 24'd1;
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_gtimer_nxt = '0;
      end
    endcase
  end

  target_ctrl #(.TARGET_MS(TARGET_MS)) u_t1 (
    .i_clk        (clock),
    .i_rst_n      (ctrl_reset_n),
    .i_run        (w_run),
    .i_tick       (w_tick),
    .i_active     (t1active_read[0]),
    .i_sensor     (t1_sensor),
    .i_force_idle (w_game_end),
    .o_timer      (w_t1_timer),
    .o_code       (w_t1_code)
  );

  target_ctrl #(.TARGET_MS(TARGET_MS)) u_t2 (
    .i_clk        (clock),
    .i_rst_n      (ctrl_reset_n),
    .i_run        (w_run),
    .i_tick       (w_tick),
    .i_active     (t2active_read[0]),
    .i_sensor     (t2_sensor),
    .i_force_idle (w_game_end),
    .o_timer      (w_t2_timer),
    .o_code       (w_t2_code)
  );

  assign timer1_write    = {16'd0, w_t1_timer};
  assign timer2_write    = {16'd0, w_t2_timer};
  assign gametimer_write = {8'd0, r_gtimer};
  assign t1hit_write     = {30'd0, w_t1_code};
  assign t2hit_write     = {30'd0, w_t2_code};
  assign game_over       = (r_state == OVER);

endmodule

// File: tb/tb_game_timer_ctrl.sv
// Self-checking bench for game_timer_ctrl: directed scenarios plus randomized
// traffic compared against a tick-counting reference model.
module tb_game_timer_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int TARGET_MS = 5;
  localparam int GAME_MS   = 20;

  logic        clock;
  logic        ctrl_reset_n;
  logic        game_start;
  logic [31:0] t1active_read, t2active_read;
  logic        t1_sensor, t2_sensor;
  logic [31:0] timer1_write, timer2_write, gametimer_write;
  logic [31:0] t1hit_write, t2hit_write;
  logic        game_over;

  int n_checks = 0;
  int n_errors = 0;

  game_timer_ctrl #(
    .TICK_DIV (TICK_DIV),
    .TARGET_MS(TARGET_MS),
    .GAME_MS  (GAME_MS)
  ) dut (
    .clock          (clock),
    .ctrl_reset_n   (ctrl_reset_n),
    .game_start     (game_start),
    .t1active_read  (t1active_read),
    .t2active_read  (t2active_read),
    .t1_sensor      (t1_sensor),
    .t2_sensor      (t2_sensor),
    .timer1_write   (timer1_write),
    .timer2_write   (timer2_write),
    .gametimer_write(gametimer_write),
    .t1hit_write    (t1hit_write),
    .t2hit_write    (t2hit_write),
    .game_over      (game_over)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  // Game time is derived from elapsed cycles since RUN entry; a target's
  // remaining window is TARGET_MS minus the ms ticks seen since it armed.
  int m_cyc, m_phase, m_start, m_ticks;   // phase: 0 idle, 1 run, 2 over
  int m_ts[2], m_arm[2], m_frz[2], m_code[2]; // ts: 0 idle, 1 armed, 2 resolved

  task automatic model_clear();
    m_phase = 0; m_start = 0; m_ticks = 0;
    for (int i = 0; i < 2; i++) begin
      m_ts[i] = 0; m_arm[i] = 0; m_frz[i] = 0; m_code[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit act[2], sens[2];
    bit was_run, ending;
    int old_ticks;
    m_cyc++;
    if (!ctrl_reset_n) begin
      model_clear();
      return;
    end
    act[0] = t1active_read[0]; act[1] = t2active_read[0];
    sens[0] = t1_sensor;       sens[1] = t2_sensor;
    was_run   = (m_phase == 1);
    old_ticks = m_ticks;
    if (was_run) m_ticks = (m_cyc - m_start) / TICK_DIV;
    ending = was_run && (m_ticks == GAME_MS);
    for (int i = 0; i < 2; i++) begin
      if (ending) begin
        m_ts[i] = 0; m_code[i] = 0; m_frz[i] = 0;
      end else if (m_ts[i] == 0) begin
        if (was_run && act[i]) begin
          m_ts[i] = 1; m_arm[i] = m_ticks;
        end
      end else if (m_ts[i] == 1) begin
        if (!act[i]) begin
          m_ts[i] = 0; m_code[i] = 0;
        end else if (sens[i]) begin
          m_ts[i] = 2; m_code[i] = 1; m_frz[i] = TARGET_MS - (old_ticks - m_arm[i]);
        end else if (TARGET_MS - (m_ticks - m_arm[i]) == 0) begin
          m_ts[i] = 2; m_code[i] = 2; m_frz[i] = 0;
        end
      end else begin
        if (!act[i]) begin
          m_ts[i] = 0; m_code[i] = 0; m_frz[i] = 0;
        end
      end
    end
    if (ending) begin
      m_phase = 2;
    end else if (!was_run && game_start) begin
      m_phase = 1; m_start = m_cyc; m_ticks = 0;
    end
  endtask

  function automatic int exp_timer(int i);
    if (m_ts[i] == 1) return TARGET_MS - (m_ticks - m_arm[i]);
    if (m_ts[i] == 2) return m_frz[i];
    return 0;
  endfunction

  function automatic int exp_gt();
    return (m_phase == 1) ? GAME_MS - m_ticks : 0;
  endfunction

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic pulse_start();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    ctrl_reset_n = 1'b0;
    model_clear();
    repeat (3) step();
    n_checks++;
    if ({timer1_write, timer2_write, gametimer_write, t1hit_write, t2hit_write} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: actual t1=%0d t2=%0d gt=%0d h1=%0d h2=%0d required all 0",
               timer1_write, timer2_write, gametimer_write, t1hit_write, t2hit_write);
    end
    n_checks++;
    if (game_over !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_game_over: actual=%b required=0", game_over);
    end
    ctrl_reset_n = 1'b1;
    step();
    t1active_read = 32'd1;
    repeat (10) step();
    n_checks++;
    if (timer1_write !== 32'd0 || t1hit_write !== 32'd0) begin
      n_errors++;
      $display("FAIL idle_no_arm: actual timer1=%0d hit1=%0d required 0/0", timer1_write, t1hit_write);
    end
    n_checks++;
    if (gametimer_write !== 32'd0) begin
      n_errors++;
      $display("FAIL idle_gametimer: actual=%0d required=0", gametimer_write);
    end
    t1active_read = 32'd0;
    step();
  endtask

  task automatic test_full_game();
    int exp_g;
    pulse_start();
    n_checks++;
    if (gametimer_write !== 32'(GAME_MS)) begin
      n_errors++;
      $display("FAIL game_load: actual=%0d required=%0d", gametimer_write, GAME_MS);
    end
    for (int k = 1; k <= GAME_MS * TICK_DIV; k++) begin
      game_start = (k == 30);
      step();
      game_start = 1'b0;
      exp_g = (k < GAME_MS * TICK_DIV) ? GAME_MS - k / TICK_DIV : 0;
      n_checks++;
      if (gametimer_write !== 32'(exp_g) || game_over !== (k == GAME_MS * TICK_DIV)) begin
        n_errors++;
        $display("FAIL game_count k=%0d: actual gt=%0d over=%b required gt=%0d over=%b",
                 k, gametimer_write, game_over, exp_g, (k == GAME_MS * TICK_DIV));
      end
    end
    repeat (3) step();
    n_checks++;
    if (game_over !== 1'b1 || gametimer_write !== 32'd0) begin
      n_errors++;
      $display("FAIL over_hold: actual over=%b gt=%0d required 1/0", game_over, gametimer_write);
    end
  endtask

  task automatic test_hit();
    int budget;
    pulse_start();
    t1active_read = 32'd1;
    step();
    n_checks++;
    if (timer1_write !== 32'(TARGET_MS) || t1hit_write !== 32'd0) begin
      n_errors++;
      $display("FAIL hit_arm: actual timer1=%0d hit1=%0d required %0d/0", timer1_write, t1hit_write, TARGET_MS);
    end
    budget = 0;
    while (timer1_write !== 32'd3 && budget < 40) begin
      step();
      budget++;
    end
    n_checks++;
    if (budget >= 40) begin
      n_errors++;
      $display("FAIL hit_reach3: actual timer1=%0d required=3 within 40 cycles", timer1_write);
    end
    t1_sensor = 1'b1;
    step();
    t1_sensor = 1'b0;
    n_checks++;
    if (t1hit_write !== 32'd1 || timer1_write !== 32'd3) begin
      n_errors++;
      $display("FAIL hit_code: actual hit1=%0d timer1=%0d required 1/3", t1hit_write, timer1_write);
    end
    repeat (2 * TICK_DIV) step();
    n_checks++;
    if (t1hit_write !== 32'd1 || timer1_write !== 32'd3) begin
      n_errors++;
      $display("FAIL hit_freeze: actual hit1=%0d timer1=%0d required 1/3", t1hit_write, timer1_write);
    end
    t1active_read = 32'd0;
    step();
    n_checks++;
    if (t1hit_write !== 32'd0 || timer1_write !== 32'd0) begin
      n_errors++;
      $display("FAIL hit_clear: actual hit1=%0d timer1=%0d required 0/0", t1hit_write, timer1_write);
    end
  endtask

  task automatic test_miss();
    int prev, budget;
    t2active_read = 32'd1;
    step();
    n_checks++;
    if (timer2_write !== 32'(TARGET_MS)) begin
      n_errors++;
      $display("FAIL miss_arm: actual timer2=%0d required=%0d", timer2_write, TARGET_MS);
    end
    prev = TARGET_MS;
    budget = 0;
    while (timer2_write !== 32'd0 && budget < 40) begin
      step();
      budget++;
      n_checks++;
      if (timer2_write !== 32'(exp_timer(1)) || t2hit_write !== 32'(m_code[1]) ||
          (timer2_write != 32'(prev) && timer2_write != 32'(prev - 1))) begin
        n_errors++;
        $display("FAIL miss_step: actual timer2=%0d hit2=%0d required %0d/%0d (prev %0d)",
                 timer2_write, t2hit_write, exp_timer(1), m_code[1], prev);
      end
      prev = int'(timer2_write);
    end
    n_checks++;
    if (t2hit_write !== 32'd2 || timer2_write !== 32'd0) begin
      n_errors++;
      $display("FAIL miss_code: actual hit2=%0d timer2=%0d required 2/0", t2hit_write, timer2_write);
    end
    t2_sensor = 1'b1;
    step();
    t2_sensor = 1'b0;
    n_checks++;
    if (t2hit_write !== 32'd2) begin
      n_errors++;
      $display("FAIL miss_sticky: actual hit2=%0d required=2", t2hit_write);
    end
    t2active_read = 32'd0;
    step();
  endtask

  task automatic test_simultaneous();
    int budget;
    t1active_read = 32'd1;
    step();
    budget = 0;
    while (!(timer1_write == 32'd1 && ((m_cyc + 1 - m_start) % TICK_DIV) == 0) && budget < 40) begin
      step();
      budget++;
    end
    t1_sensor = 1'b1;
    step();
    t1_sensor = 1'b0;
    n_checks++;
    if (t1hit_write !== 32'd1 || timer1_write !== 32'd1) begin
      n_errors++;
      $display("FAIL hit_on_final_tick: actual hit1=%0d timer1=%0d required 1/1", t1hit_write, timer1_write);
    end
    t1active_read = 32'd0;
    t2active_read = 32'd1;
    step();
    t2active_read = 32'd0;
    t2_sensor = 1'b1;
    step();
    t2_sensor = 1'b0;
    n_checks++;
    if (t2hit_write !== 32'd0 || timer2_write !== 32'd0) begin
      n_errors++;
      $display("FAIL cancel_beats_sensor: actual hit2=%0d timer2=%0d required 0/0", t2hit_write, timer2_write);
    end
  endtask

  task automatic test_game_end();
    int budget;
    t1active_read = 32'd1;
    step();
    t1_sensor = 1'b1;
    step();
    t1_sensor = 1'b0;
    n_checks++;
    if (t1hit_write !== 32'(m_code[0]) || timer1_write !== 32'(exp_timer(0))) begin
      n_errors++;
      $display("FAIL end_prehit: actual hit1=%0d timer1=%0d required %0d/%0d",
               t1hit_write, timer1_write, m_code[0], exp_timer(0));
    end
    budget = 0;
    while (game_over !== 1'b1 && budget < 100) begin
      step();
      budget++;
    end
    n_checks++;
    if (game_over !== 1'b1 || t1hit_write !== 32'd0 || timer1_write !== 32'd0) begin
      n_errors++;
      $display("FAIL end_force_idle: actual over=%b hit1=%0d timer1=%0d required 1/0/0",
               game_over, t1hit_write, timer1_write);
    end
    repeat (3) step();
    n_checks++;
    if (timer1_write !== 32'd0) begin
      n_errors++;
      $display("FAIL over_no_arm: actual timer1=%0d required=0", timer1_write);
    end
    t1active_read = 32'd0;
    step();
  endtask

  task automatic test_reset_mid_run();
    pulse_start();
    t1active_read = 32'd1;
    repeat (6) step();
    #2;
    ctrl_reset_n = 1'b0;
    #1;
    model_clear();
    n_checks++;
    if ({timer1_write, t1hit_write, gametimer_write} !== '0 || game_over !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset: actual timer1=%0d hit1=%0d gt=%0d over=%b required all 0",
               timer1_write, t1hit_write, gametimer_write, game_over);
    end
    repeat (2) step();
    ctrl_reset_n = 1'b1;
    repeat (10) step();
    n_checks++;
    if (gametimer_write !== 32'd0 || game_over !== 1'b0 || timer1_write !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_stays_idle: actual gt=%0d over=%b timer1=%0d required 0/0/0",
               gametimer_write, game_over, timer1_write);
    end
    t1active_read = 32'd0;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      game_start = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) t1active_read = {$urandom(), 1'b0} | 32'(~t1active_read[0]);
      if ($urandom_range(0, 11) == 0) t2active_read = {$urandom(), 1'b0} | 32'(~t2active_read[0]);
      t1_sensor = ($urandom_range(0, 5) == 0);
      t2_sensor = ($urandom_range(0, 5) == 0);
      step();
      n_checks++;
      if (gametimer_write !== 32'(exp_gt()) || game_over !== (m_phase == 2)) begin
        n_errors++;
        if (n_errors < 20)
          $display("FAIL rand_game c=%0d: actual gt=%0d over=%b required %0d/%b",
                   c, gametimer_write, game_over, exp_gt(), (m_phase == 2));
      end
      n_checks++;
      if (timer1_write !== 32'(exp_timer(0)) || t1hit_write !== 32'(m_code[0])) begin
        n_errors++;
        if (n_errors < 20)
          $display("FAIL rand_t1 c=%0d: actual timer1=%0d hit1=%0d required %0d/%0d",
                   c, timer1_write, t1hit_write, exp_timer(0), m_code[0]);
      end
      n_checks++;
      if (timer2_write !== 32'(exp_timer(1)) || t2hit_write !== 32'(m_code[1])) begin
        n_errors++;
        if (n_errors < 20)
          $display("FAIL rand_t2 c=%0d: actual timer2=%0d hit2=%0d required %0d/%0d",
                   c, timer2_write, t2hit_write, exp_timer(1), m_code[1]);
      end
    end
    game_start = 1'b0;
    t1_sensor  = 1'b0;
    t2_sensor  = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    m_cyc         = 0;
    ctrl_reset_n  = 1'b0;
    game_start    = 1'b0;
    t1active_read = 32'd0;
    t2active_read = 32'd0;
    t1_sensor     = 1'b0;
    t2_sensor     = 1'b0;
    model_clear();

    test_reset();
    test_full_game();
    test_hit();
    test_miss();
    test_simultaneous();
    test_game_end();
    test_reset_mid_run();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_timer_ctrl.md
# game_timer_ctrl

Hardware sequencer for the game's timer and target-hit registers. Runs a millisecond prescaler, a game countdown, and two per-target reaction-window state machines. Its registered outputs drive the register file's hardware-write ports (timer1, timer2, gametimer, t1hit, t2hit). The processor arms a target by setting its active register and acknowledges a result by clearing it again; the block reads those active registers back.

## Interface
- `TICK_DIV`, 50000: clock cycles per 1 ms tick; must be ≥ 2.
- `TARGET_MS`, 1000: reaction window per arming, in ticks; 1..65535.
- `GAME_MS`, 60000: game length in ticks; 1..16777215.
- `clock` in 1: single clock; all state on rising edge.
- `ctrl_reset_n` in 1: reset, asynchronous, active-low.
- `game_start` in 1: one-cycle start pulse from I/O.
- `t1active_read` in 32: target-1 active register; only bit 0 is used.
- `t2active_read` in 32: target-2 active register; only bit 0 is used.
- `t1_sensor` in 1: target-1 hit strobe, already synchronized upstream.
- `t2_sensor` in 1: target-2 hit strobe, already synchronized upstream.
- `timer1_write` out 32: remaining target-1 window in ms, zero-extended from 16 bits.
- `timer2_write` out 32: remaining target-2 window in ms, zero-extended from 16 bits.
- `gametimer_write` out 32: remaining game time in ms, zero-extended from 24 bits.
- `t1hit_write` out 32: target-1 result code.
- `t2hit_write` out 32: target-2 result code.
- `game_over` out 1: high while the game FSM is in OVER.

## Operation
- Result codes: 0 = none, 1 = hit, 2 = miss.
- Prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN.
  - `tick` pulses for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
  - The count is cleared on entry to RUN.
- Game FSM:
  - IDLE: `game_start` → RUN, with gametimer loaded to GAME_MS.
  - RUN: each tick decrements gametimer. A tick with gametimer == 1 sets it to 0 and goes to OVER.
  - OVER: holds. `game_start` → RUN with a fresh load.
  - `game_start` while in RUN is ignored; there is no restart.
- Target FSM, one instance per target:
  - T_IDLE: timer = 0, code = 0. If in RUN and active = 1 → T_ARMED, with timer loaded to TARGET_MS.
  - T_ARMED:
    - active = 0 → T_IDLE (software cancel).
    - Otherwise sensor = 1 → T_HIT, code 1, timer frozen.
    - Otherwise a tick decrements the timer. A tick with timer == 1 → T_MISS, code 2, timer 0.
  - T_HIT / T_MISS: code and timer held until active = 0, then → T_IDLE.
  - A result is never overwritten while active stays 1; repeated sensor pulses are ignored.
- Priority within one cycle:
  - cancel (active = 0) > sensor > expiry tick.
  - A hit on the same cycle as the final tick is a hit.
- Game end: in the cycle the game enters OVER, every target is forced to T_IDLE (timer 0, code 0), including targets in T_HIT or T_MISS.
- Targets do not arm in IDLE or OVER, even with active = 1. They arm on the first RUN cycle in which active = 1.
- Game start in OVER with active already 1: targets arm one cycle after RUN is entered.

## Timing
- Reset values:
  - All outputs 0, `game_over` 0.
  - Game FSM IDLE, targets T_IDLE, prescaler 0.
- Reset is honoured mid-game, and no other input overrides it.
- All outputs are registered.
- `sensor` high at edge N → code and freeze visible after edge N. The register file captures the value at edge N+1.
- `active` change at edge N → FSM reacts at edge N+1.
- Tick spacing:
  - The first tick occurs TICK_DIV cycles after RUN entry.
  - gametimer reaches 0, and `game_over` rises, at the edge of tick GAME_MS, i.e. GAME_MS·TICK_DIV cycles after the RUN-entry edge.
- The target window expires on the TARGET_MS-th tick after arming. The first tick may be partial, because the prescaler is shared.

## Structure
- Package `game_pkg`:
  - game FSM encoding: IDLE, RUN, OVER;
  - target FSM encoding: T_IDLE, T_ARMED, T_HIT, T_MISS;
  - result-code constants: RES_NONE = 0, RES_HIT = 1, RES_MISS = 2.
- Sub-module `target_ctrl`, instantiated twice:
  - inputs: clock, reset, run, tick, active, sensor, force_idle;
  - outputs: 16-bit timer, 2-bit code;
  - parameter: TARGET_MS.
- The top level holds the prescaler, the game FSM, and the zero-extension to 32 bits.

## Test plan
Parameters for all scenarios: TICK_DIV = 4, TARGET_MS = 5, GAME_MS = 20.
- Reset then idle:
  - `ctrl_reset_n` low → all outputs 0.
  - `t1active_read` = 1 without `game_start` → target does not arm; `timer1_write` stays 0.
- Full game:
  - `game_start` pulse → `gametimer_write` = 20, then decrements every 4 cycles.
  - `game_over` = 1 with `gametimer_write` = 0 exactly 80 cycles after the RUN-entry edge.
  - `game_start` mid-RUN has no effect.
- Hit:
  - Arm t1, then `t1_sensor` pulse on the cycle `timer1_write` = 3 → `t1hit_write` = 1 one cycle later, and `timer1_write` holds 3.
  - Clear active → both return to 0.
- Miss:
  - Arm t2 with no sensor → `timer2_write` steps 5..1 and reaches 0 on the 5th tick, with `t2hit_write` = 2.
  - A later sensor pulse leaves the code at 2.
- Simultaneous events:
  - Sensor on the cycle of the final tick → code 1 (hit wins).
  - Active cleared on the same cycle as a sensor pulse → T_IDLE, code 0.
- Game end and reset:
  - t1 in T_HIT when `game_over` rises → `t1hit_write` and `timer1_write` forced to 0.
  - `ctrl_reset_n` asserted mid-RUN → all outputs 0 asynchronously, and the block stays IDLE after release.
